// File: rtl/fifo_rd_downsizer_pkg.sv
// Shared types and sizing helpers for the FIFO read-side downsizer.
// Chunk order is selected by FIFO_RD_DOWNSIZER_MSB_FIRST_EN (see fifo_rd_downsizer_chunk_sel).
package fifo_rd_downsizer_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   function automatic int ratio_f(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Counter width never drops below one bit, so RATIO=2 still gets a real register.
   function automatic int cnt_w_f(input int ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction

endpackage

// File: rtl/fifo_rd_downsizer_if.sv
// FIFO read port plus downstream chunk stream, seen from the downsizer (master) and its environment (slave).
// Stream: a chunk transfers on a cycle where out_valid=1 and out_ready=1; once raised, out_valid, out_data
// and out_last hold until that transfer. FIFO: a word is popped at the posedge where fifo_ren=1.
interface fifo_rd_downsizer_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 4
);
   logic [IN_WIDTH-1:0]  fifo_rdata;
   logic                 fifo_empty;
   logic                 fifo_ren;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport master (
      input  fifo_rdata, fifo_empty, out_ready,
      output fifo_ren, out_data, out_valid, out_last
   );

   modport slave (
      output fifo_rdata, fifo_empty, out_ready,
      input  fifo_ren, out_data, out_valid, out_last
   );
endinterface

// File: rtl/fifo_rd_downsizer_chunk_sel.sv
// Combinational word -> chunk mux. Define FIFO_RD_DOWNSIZER_MSB_FIRST_EN for MSB-chunk-first order;
// default is LSB chunk first.
module fifo_rd_downsizer_chunk_sel
   import fifo_rd_downsizer_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 4
) (
   input  logic [IN_WIDTH-1:0]                               word,
   input  logic [cnt_w_f(ratio_f(IN_WIDTH, OUT_WIDTH))-1:0] idx,
   output logic [OUT_WIDTH-1:0]                              chunk
);
   localparam int RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);
   localparam int CNT_W = cnt_w_f(RATIO);

   // Unused index codes (RATIO not a power of two) select zero.
   always_comb begin
      chunk = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (idx == CNT_W'(k)) begin
`ifdef FIFO_RD_DOWNSIZER_MSB_FIRST_EN
            chunk = word[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
            chunk = word[k*OUT_WIDTH +: OUT_WIDTH];
`endif
         end
      end
   end
endmodule

// File: rtl/fifo_rd_downsizer.sv
// Drains the async FIFO read port and streams each word as RATIO chunks, one per cycle, no inter-word bubble.
// Chunk order follows FIFO_RD_DOWNSIZER_MSB_FIRST_EN inside fifo_rd_downsizer_chunk_sel.
module fifo_rd_downsizer
   import fifo_rd_downsizer_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   fifo_rd_downsizer_if.master        bus,
   output state_e                     dbg_state
);
   localparam int RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);
   localparam int CNT_W = cnt_w_f(RATIO);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

   if ((IN_WIDTH % OUT_WIDTH) != 0 || (IN_WIDTH / OUT_WIDTH) < 2) begin : g_bad_widths
      $fatal(1, "fifo_rd_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
   end

   state_e               state_q;
   logic [IN_WIDTH-1:0]  word_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 active;
   logic                 last;
   logic                 acc;
   logic                 ren;

   assign active = (state_q == ACTIVE);
   assign last   = active && (cnt_q == LAST_IDX);
   assign acc    = active && bus.out_ready;

   // Pop only when holding nothing, or in the very cycle the final chunk leaves.
   assign ren    = rst && !bus.fifo_empty && (!active || (acc && last));

   assign bus.out_valid = active;
   assign bus.out_last  = last;
   assign bus.fifo_ren  = ren;
   assign dbg_state     = state_q;

   fifo_rd_downsizer_chunk_sel #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_chunk_sel (
      .word  (word_q),
      .idx   (cnt_q),
      .chunk (bus.out_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ren) begin
                  word_q  <= bus.fifo_rdata;
                  cnt_q   <= '0;
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (acc) begin
                  if (!last) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else begin
                     cnt_q <= '0;
                     if (ren) word_q  <= bus.fifo_rdata;
                     else     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Directed bench for fifo_rd_downsizer with a FIFO queue model and an expected-chunk scoreboard.
// Build with FIFO_RD_DOWNSIZER_MSB_FIRST_EN defined to check the MSB-first order.
module tb_fifo_rd_downsizer;
   import fifo_rd_downsizer_pkg::*;

   localparam int IN_W  = 16;
   localparam int OUT_W = 4;
   localparam int RATIO = IN_W / OUT_W;

   logic   clk;
   logic   rst;
   state_e dbg_state;

   fifo_rd_downsizer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

   fifo_rd_downsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [IN_W-1:0]  fifo_q[$];
   logic [OUT_W:0]   exp_q[$];

   int checks   = 0;
   int failures = 0;
   int ren_cnt, acc_cnt, valid_cnt;

   logic             s_ren, s_valid, s_last, s_ready, s_rst;
   logic [OUT_W-1:0] s_data;
   logic             p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_rst = 1'b0;
   logic [OUT_W-1:0] p_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference chunk k of a word, computed by shifting rather than slicing.
   function automatic logic [OUT_W-1:0] ref_chunk(input logic [IN_W-1:0] w, input int k);
      logic [IN_W-1:0] sh;
`ifdef FIFO_RD_DOWNSIZER_MSB_FIRST_EN
      sh = w >> (IN_W - (k + 1) * OUT_W);
`else
      sh = w >> (k * OUT_W);
`endif
      return sh[OUT_W-1:0];
   endfunction

   task automatic fifo_drive();
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   task automatic push_word(input logic [IN_W-1:0] w);
      fifo_q.push_back(w);
      fifo_drive();
   endtask

   task automatic clear_counts();
      ren_cnt   = 0;
      acc_cnt   = 0;
      valid_cnt = 0;
   endtask

   // One clock: sample just after the falling edge, monitor, then advance to the next falling edge.
   task automatic cycle();
      logic       pop;
      logic [OUT_W:0] e;
      pop = 1'b0;
      #1;
      s_ren   = bus.fifo_ren;
      s_valid = bus.out_valid;
      s_data  = bus.out_data;
      s_last  = bus.out_last;
      s_ready = bus.out_ready;
      s_rst   = rst;
      if (!s_rst) chk("ren_in_reset", s_ren, 1'b0);
      if (s_ren) begin
         ren_cnt++;
         chk("ren_not_empty", fifo_q.size() != 0, 1'b1);
         if (s_valid) chk("ren_only_on_last_acc", s_ready & s_last, 1'b1);
         if (fifo_q.size() != 0) begin
            for (int k = 0; k < RATIO; k++) exp_q.push_back({(k == RATIO - 1), ref_chunk(fifo_q[0], k)});
            pop = 1'b1;
         end
      end
      if (s_valid) valid_cnt++;
      if (s_valid && s_ready && s_rst) begin
         acc_cnt++;
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_chunk", {s_last, s_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("sb_chunk", {s_last, s_data}, e);
         end
      end
      if (p_valid && !p_ready && p_rst && s_rst) begin
         chk("hold_valid", s_valid, 1'b1);
         chk("hold_data_last", {s_last, s_data}, {p_last, p_data});
      end
      p_valid = s_valid;
      p_ready = s_ready;
      p_last  = s_last;
      p_data  = s_data;
      p_rst   = s_rst;
      @(negedge clk);
      if (pop) void'(fifo_q.pop_front());
      fifo_drive();
   endtask

   // mode 0: ready always high, 1: 1,0,0 repeating, 2: random.
   task automatic drain(input int mode, input int bound);
      logic done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((i % 3) == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         cycle();
         done = (exp_q.size() == 0) && (fifo_q.size() == 0) && !s_valid;
      end
      chk("drain_done", done, 1'b1);
   endtask

   initial begin
      rst           = 1'b0;
      bus.out_ready = 1'b0;
      fifo_drive();
      clear_counts();
      @(negedge clk);

      // Reset with a word already waiting: nothing may pop or show.
      push_word(16'hA5C3);
      cycle();
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_last", s_last, 1'b0);
      chk("rst_data", s_data, '0);
      chk("rst_state", dbg_state, IDLE);
      cycle();
      chk("rst_ren", s_ren, 1'b0);

      // Basic split of A5C3.
      rst = 1'b1;
      bus.out_ready = 1'b1;
      clear_counts();
      cycle();
      chk("lat_ren", s_ren, 1'b1);
      chk("lat_valid0", s_valid, 1'b0);
      cycle();
      chk("lat_valid1", s_valid, 1'b1);
      chk("lat_state", dbg_state, ACTIVE);
`ifdef FIFO_RD_DOWNSIZER_MSB_FIRST_EN
      chk("first_chunk", s_data, 4'hA);
`else
      chk("first_chunk", s_data, 4'h3);
`endif
      for (int i = 0; i < 4; i++) cycle();
      chk("basic_acc", acc_cnt, 4);
      chk("basic_ren", ren_cnt, 1);
      chk("basic_idle", s_valid, 1'b0);

      // Back-to-back words, no bubble.
      clear_counts();
      push_word(16'h1234);
      push_word(16'h5678);
      for (int i = 0; i < 10; i++) cycle();
      chk("b2b_valid_cycles", valid_cnt, 8);
      chk("b2b_acc", acc_cnt, 8);
      chk("b2b_ren", ren_cnt, 2);
      chk("b2b_idle", s_valid, 1'b0);

      // Backpressure 1,0,0 with a second word waiting behind a stalled last chunk.
      clear_counts();
      push_word(16'h9C6B);
      push_word(16'h2DF0);
      drain(1, 60);
      chk("bp_acc", acc_cnt, 8);
      chk("bp_ren", ren_cnt, 2);

      // Empty boundary, then a late word.
      push_word(16'hFFFF);
      drain(0, 20);
      for (int i = 0; i < 3; i++) cycle();
      chk("empty_valid", s_valid, 1'b0);
      chk("empty_ren", s_ren, 1'b0);
      chk("empty_flag", bus.fifo_empty, 1'b1);
      push_word(16'h0001);
      cycle();
      chk("late_ren", s_ren, 1'b1);
      cycle();
      chk("late_valid", s_valid, 1'b1);
`ifdef FIFO_RD_DOWNSIZER_MSB_FIRST_EN
      chk("late_chunk", s_data, 4'h0);
`else
      chk("late_chunk", s_data, 4'h1);
`endif
      drain(0, 20);

      // Reset after two chunks of BEEF; its remaining chunks must never appear.
      push_word(16'hBEEF);
      push_word(16'h1357);
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b0;
      bus.out_ready = 1'b0;
      cycle();
      chk("mid_rst_ren", s_ren, 1'b0);
      exp_q.delete();
      cycle();
      chk("mid_rst_valid", s_valid, 1'b0);
      chk("mid_rst_ren2", s_ren, 1'b0);
      rst = 1'b1;
      clear_counts();
      drain(0, 20);
      chk("post_rst_acc", acc_cnt, 4);

      // Random backpressure over random words.
      clear_counts();
      for (int i = 0; i < 4; i++) push_word(16'($urandom_range(0, 65535)));
      drain(2, 300);
      chk("rand_acc", acc_cnt, 16);
      chk("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
